// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

  // Conversion FSM: idle/accepting, double-dabble running, display load.
  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StLoad
  } calc_state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int unsigned NUM_DIGITS = 4;

  // Magnitude of a signed byte as an unsigned byte; -128 maps to 128.
  function automatic logic [7:0] abs8(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: 8-bit magnitude to three BCD nibbles
// in exactly 8 shift cycles after start.
module calc_bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  mag_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic [11:0] adj;
  logic [19:0] shifted;

  // Add-3 correction on every nibble >= 5, then shift the whole register left.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, bin_q} << 1;
    bcd_d   = shifted[19:8];
    bin_d   = shifted[7:0];
  end

  // Load on start, then run 8 shifts; busy drops with the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= 8'd0;
      bcd_q  <= 12'd0;
      cnt_q  <= 3'd0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      bin_q  <= mag_i;
      bcd_q  <= 12'd0;
      cnt_q  <= 3'd0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        busy_q <= 1'b0;
      end
    end
  end

  // High during the cycle whose closing edge performs the 8th shift.
  assign done_o = busy_q && (cnt_q == 3'd7);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_digit_scan.sv
// Signed result to multiplexed 4-position seven-segment scan (sign, hundreds,
// tens, ones) with leading-zero blanking.
module calc_digit_scan
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_result,
  output logic       in_ready,
  output logic [3:0] anode,
  output logic [3:0] digit,
  output logic       neg
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [15:0] ScanLast = 16'(SCAN_DIV - 1);

  calc_state_e     state_q;
  logic            in_ready_q;
  logic            sign_q;
  logic            disp_sign_q;
  logic [3:0]      disp_hun_q, disp_ten_q, disp_one_q;
  logic [15:0]     scan_cnt_q;
  logic [IdxW-1:0] scan_idx_q;
  logic            accept;
  logic [11:0]     bcd;
  logic            conv_done;
  logic            disp_nz;

  assign accept   = in_valid & in_ready_q;
  assign in_ready = in_ready_q;

  calc_bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .mag_i   (abs8(in_result)),
    .bcd_o   (bcd),
    .done_o  (conv_done)
  );

  // Conversion FSM with registered ready and the display registers it loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      sign_q      <= 1'b0;
      disp_sign_q <= 1'b0;
      disp_hun_q  <= 4'd0;
      disp_ten_q  <= 4'd0;
      disp_one_q  <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StConv;
            in_ready_q <= 1'b0;
            sign_q     <= in_result[7];
          end
        end
        StConv: begin
          if (conv_done) begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          // All four display registers change on the same edge.
          disp_sign_q <= sign_q;
          disp_hun_q  <= bcd[11:8];
          disp_ten_q  <= bcd[7:4];
          disp_one_q  <= bcd[3:0];
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Free-running scan divider; each wrap moves to the next lower position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= 16'd0;
      scan_idx_q <= IdxW'(NUM_DIGITS - 1);
    end else if (scan_cnt_q == ScanLast) begin
      scan_cnt_q <= 16'd0;
      scan_idx_q <= scan_idx_q - IdxW'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + 16'd1;
    end
  end

  assign disp_nz = |{disp_hun_q, disp_ten_q, disp_one_q};

  // Position decode: one active-low anode, blanked BCD digit, sign flag.
  always_comb begin
    anode             = 4'b1111;
    digit             = BLANK_CODE;
    neg               = 1'b0;
    anode[scan_idx_q] = 1'b0;
    unique case (scan_idx_q)
      2'd3: neg = disp_sign_q && disp_nz;
      2'd2: digit = (disp_hun_q == 4'd0) ? BLANK_CODE : disp_hun_q;
      2'd1: digit = ((disp_hun_q == 4'd0) && (disp_ten_q == 4'd0)) ? BLANK_CODE : disp_ten_q;
      2'd0: digit = disp_one_q;
      default: digit = BLANK_CODE;
    endcase
  end

endmodule

// File: tb/tb_calc_digit_scan.sv
// Bench for calc_digit_scan with a fast scan (SCAN_DIV=4).
module tb_calc_digit_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_result;
  logic       in_ready;
  logic [3:0] anode;
  logic [3:0] digit;
  logic       neg;

  int checks = 0;
  int errors = 0;
  int cyc;      // rising edges since reset release
  int cur_val;  // value the display is expected to show

  calc_digit_scan #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_result (in_result),
    .in_ready  (in_ready),
    .anode     (anode),
    .digit     (digit),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected position lit: 4 cycles per position, starting at the sign.
  function automatic int exp_pos(input int c);
    return 3 - ((c / 4) % 4);
  endfunction

  function automatic logic [3:0] exp_digit(input int val, input int pos);
    int mag;
    mag = (val < 0) ? -val : val;
    case (pos)
      3:       return 4'hF;
      2:       return (mag < 100) ? 4'hF : 4'(mag / 100);
      1:       return (mag < 10) ? 4'hF : 4'((mag / 10) % 10);
      default: return 4'(mag % 10);
    endcase
  endfunction

  function automatic logic exp_neg(input int val, input int pos);
    return (pos == 3) && (val < 0);
  endfunction

  task automatic check_now(input string tag);
    int p;
    logic [3:0] ea;
    p  = exp_pos(cyc);
    ea = 4'b1111;
    ea[p] = 1'b0;
    checks += 3;
    if (anode !== ea) begin
      errors++;
      $display("FAIL %s anode cyc=%0d got=%b exp=%b", tag, cyc, anode, ea);
    end
    if (digit !== exp_digit(cur_val, p)) begin
      errors++;
      $display("FAIL %s digit val=%0d pos=%0d got=%h exp=%h", tag, cur_val, p, digit,
               exp_digit(cur_val, p));
    end
    if (neg !== exp_neg(cur_val, p)) begin
      errors++;
      $display("FAIL %s neg val=%0d pos=%0d got=%b exp=%b", tag, cur_val, p, neg,
               exp_neg(cur_val, p));
    end
  endtask

  task automatic check_display(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check_now(tag);
    end
  endtask

  // Wait for ready, present v, and follow the 9-cycle conversion to the update.
  task automatic send(input string tag, input int v, input bit align_wrap);
    int k;
    k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout got=%b exp=1", tag, in_ready);
    end
    // Update edge is accept+9; land it on a scan wrap edge.
    if (align_wrap) begin
      while ((cyc % 4) != 2) @(negedge clk);
    end
    in_valid  = 1'b1;
    in_result = 8'(v);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s ready_low cycle=%0d got=%b exp=0", tag, i, in_ready);
      end
      if ($countones(~anode) != 1) begin
        checks++;
        errors++;
        $display("FAIL %s anode_onehot got=%b exp=one zero", tag, anode);
      end
      check_now(tag);
    end
    cur_val = v;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_back got=%b exp=1", tag, in_ready);
    end
    check_now(tag);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = 8'd0;
    cur_val   = 0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    if (anode !== 4'b0111) begin errors++; $display("FAIL rst_anode got=%b exp=0111", anode); end
    if (digit !== 4'hF) begin errors++; $display("FAIL rst_digit got=%h exp=f", digit); end
    if (neg !== 1'b0) begin errors++; $display("FAIL rst_neg got=%b exp=0", neg); end
    rst = 1'b0;
    check_display("reset_scan", 16);
  endtask

  task automatic test_neg_min();
    send("neg_min", -128, 1'b0);
    check_display("neg_min_show", 16);
  endtask

  task automatic test_values();
    int vals[3] = '{7, 105, 0};
    foreach (vals[i]) begin
      send("values", vals[i], 1'b0);
      check_display("values_show", 16);
    end
  endtask

  // Second value held on in_valid during the first conversion.
  task automatic test_back_to_back();
    send("b2b_a_prep", 42, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_result = 8'(-99);
    @(posedge clk);
    #1 in_result = 8'(57);  // keep valid, new value while busy
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy cycle=%0d got=%b exp=0", i, in_ready);
      end
      check_now("b2b_old");
    end
    cur_val = -99;
    @(negedge clk);
    check_now("b2b_first");
    // Ready is high here, so the held 57 is taken on the next edge.
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second_busy cycle=%0d got=%b exp=0", i, in_ready);
      end
      check_now("b2b_hold_first");
    end
    cur_val = 57;
    check_display("b2b_second", 8);
  endtask

  // Reset pulse mid-conversion, then a transfer on the first edge after release.
  task automatic test_abort();
    send("abort_prep", 88, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_result = 8'(-55);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    cur_val = 0;
    checks += 3;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
    if (anode !== 4'b0111) begin errors++; $display("FAIL abort_anode got=%b exp=0111", anode); end
    if (digit !== 4'hF) begin errors++; $display("FAIL abort_digit got=%h exp=f", digit); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_ready_stay got=%b exp=1", in_ready);
      end
      check_now("abort_zero");
    end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_result = 8'(33);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_accept got=%b exp=0", in_ready);
    end
    check_display("first_edge_old", 8);
    cur_val = 33;
    check_display("first_edge_new", 16);
  endtask

  task automatic test_wrap();
    send("wrap", -1, 1'b1);
    check_display("wrap_show", 16);
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 8; n++) begin
      v = int'($urandom_range(255, 0)) - 128;
      send("random", v, n[0]);
      check_display("random_show", 16);
    end
  endtask

  initial begin
    test_reset();
    test_neg_min();
    test_values();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
